// File: rtl/ha_pack_pkg.sv
// Shared constants and helpers for the half-adder result packer.
// Holds the count-field width helper, the sum/carry slot offsets inside a
// packed word and a count type wide enough for the largest legal pack width.
package ha_pack_pkg;

    localparam int unsigned MAX_PACK_WIDTH = 32;
    localparam int unsigned MAX_CNT_W      = $clog2(MAX_PACK_WIDTH + 1);
    localparam int unsigned SUM_LSB        = 0;

    // Width of a field that can hold 0..pack_width
    function automatic int unsigned cnt_width(input int unsigned pack_width);
        return $clog2(pack_width + 1);
    endfunction

    // Carry slots sit directly above the sum slots
    function automatic int unsigned carry_lsb(input int unsigned pack_width);
        return pack_width;
    endfunction

    // Count wide enough for any legal configuration; used for fill arithmetic
    typedef logic [MAX_CNT_W-1:0] pack_cnt_t;

endpackage

// File: rtl/ha_pack_out_reg.sv
// Output register slice of the result packer: holds one packed beat.
// Optional macro HA_PACK_CARRY_CNT_EN adds m_pack_tuser (carry popcount).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load              capture load_data/load_count this edge (only when out_free_c)
//   load_data/count   packed word and its valid-slot count
//   out_free_c        register empty or being drained this cycle
//   m_pack_*          AXI-stream master side
module ha_pack_out_reg
    import ha_pack_pkg::*;
#(
    parameter int unsigned PACK_WIDTH = 8,
    parameter int unsigned CNT_W      = cnt_width(PACK_WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [2*PACK_WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0]        load_count,
    output logic                    out_free_c,
    output logic                    m_pack_tvalid,
    output logic [2*PACK_WIDTH-1:0] m_pack_tdata,
    output logic [CNT_W-1:0]        m_pack_tcount,
`ifdef HA_PACK_CARRY_CNT_EN
    output logic [CNT_W-1:0]        m_pack_tuser,
`endif
    input  logic                    m_pack_tready
);

    localparam int unsigned DATA_W    = 2 * PACK_WIDTH;
    localparam int unsigned CARRY_LSB = carry_lsb(PACK_WIDTH);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;

    assign out_free_c = !valid_q || m_pack_tready;

    // Hold the beat until accepted; a new load may replace it on the accept edge
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            count_d = load_count;
        end else if (m_pack_tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign m_pack_tvalid = valid_q;
    assign m_pack_tdata  = data_q;
    assign m_pack_tcount = count_q;

`ifdef HA_PACK_CARRY_CNT_EN
    logic [CNT_W-1:0] user_q, user_d;

    // Unfilled carry slots are zero, so the plain popcount counts valid slots only
    always_comb begin
        user_d = user_q;
        if (load) begin
            user_d = '0;
            for (int i = 0; i < int'(PACK_WIDTH); i++) begin
                user_d = user_d + CNT_W'(load_data[CARRY_LSB + i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            user_q <= '0;
        end else begin
            user_q <= user_d;
        end
    end

    assign m_pack_tuser = user_q;
`endif

endmodule

// File: rtl/ha_result_packer.sv
// Joins the half-adder sum and carry streams into pairs and packs PACK_WIDTH
// pairs into one wide beat, double-buffered behind ha_pack_out_reg.
// Optional macro HA_PACK_CARRY_CNT_EN adds m_pack_tuser (carry popcount).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   s_sum_*, s_carry_*      1-bit slave streams, transferred together
//   flush                   one-cycle request to emit a partial word
//   m_pack_*                packed master stream (tdata: sum slots low, carry high)
module ha_result_packer
    import ha_pack_pkg::*;
#(
    parameter int unsigned PACK_WIDTH = 8,
    parameter int unsigned CNT_W      = cnt_width(PACK_WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_sum_tvalid,
    input  logic                    s_sum_tdata,
    output logic                    s_sum_tready,
    input  logic                    s_carry_tvalid,
    input  logic                    s_carry_tdata,
    output logic                    s_carry_tready,
    input  logic                    flush,
    output logic                    m_pack_tvalid,
    output logic [2*PACK_WIDTH-1:0] m_pack_tdata,
    output logic [CNT_W-1:0]        m_pack_tcount,
`ifdef HA_PACK_CARRY_CNT_EN
    output logic [CNT_W-1:0]        m_pack_tuser,
`endif
    input  logic                    m_pack_tready
);

    localparam int unsigned DATA_W    = 2 * PACK_WIDTH;
    localparam int unsigned CARRY_LSB = carry_lsb(PACK_WIDTH);

    logic [PACK_WIDTH-1:0] acc_sum_q, acc_sum_d;
    logic [PACK_WIDTH-1:0] acc_carry_q, acc_carry_d;
    logic [CNT_W-1:0]      acc_count_q, acc_count_d;
    logic                  flush_pending_q, flush_pending_d;

    logic                  acc_full;
    logic                  pair_fire;
    logic                  out_free_c;
    logic                  load;
    logic [DATA_W-1:0]     load_data;
    logic [PACK_WIDTH-1:0] sum_fill, carry_fill;
    pack_cnt_t             fill_count;
    logic                  word_full, word_flush;

    assign acc_full = (acc_count_q == CNT_W'(PACK_WIDTH));

    // A pending flush freezes the partial word until it can be emitted
    assign pair_fire = !reset && s_sum_tvalid && s_carry_tvalid &&
                       !acc_full && !flush_pending_q;

    assign s_sum_tready   = pair_fire;
    assign s_carry_tready = pair_fire;

    // Word as it would look after this cycle's pair, and what to do with it
    always_comb begin
        sum_fill   = acc_sum_q;
        carry_fill = acc_carry_q;
        for (int i = 0; i < int'(PACK_WIDTH); i++) begin
            if (pair_fire && acc_count_q == CNT_W'(i)) begin
                sum_fill[i]   = s_sum_tdata;
                carry_fill[i] = s_carry_tdata;
            end
        end
        fill_count = pack_cnt_t'(acc_count_q) + pack_cnt_t'(pair_fire);
        word_full  = (fill_count == pack_cnt_t'(PACK_WIDTH));
        word_flush = (flush || flush_pending_q) && (fill_count != '0);
        load       = (word_full || word_flush) && out_free_c;

        load_data = '0;
        load_data[SUM_LSB +: PACK_WIDTH]   = sum_fill;
        load_data[CARRY_LSB +: PACK_WIDTH] = carry_fill;

        acc_sum_d       = sum_fill;
        acc_carry_d     = carry_fill;
        acc_count_d     = CNT_W'(fill_count);
        flush_pending_d = flush_pending_q;
        if (load) begin
            acc_sum_d       = '0;
            acc_carry_d     = '0;
            acc_count_d     = '0;
            flush_pending_d = 1'b0;
        end else if (word_flush && !word_full) begin
            // A full word goes out anyway, so a flush only matters for partials
            flush_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_sum_q       <= '0;
            acc_carry_q     <= '0;
            acc_count_q     <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            acc_sum_q       <= acc_sum_d;
            acc_carry_q     <= acc_carry_d;
            acc_count_q     <= acc_count_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    ha_pack_out_reg #(
        .PACK_WIDTH (PACK_WIDTH),
        .CNT_W      (CNT_W)
    ) u_out_reg (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .load_data     (load_data),
        .load_count    (CNT_W'(fill_count)),
        .out_free_c    (out_free_c),
        .m_pack_tvalid (m_pack_tvalid),
        .m_pack_tdata  (m_pack_tdata),
        .m_pack_tcount (m_pack_tcount),
`ifdef HA_PACK_CARRY_CNT_EN
        .m_pack_tuser  (m_pack_tuser),
`endif
        .m_pack_tready (m_pack_tready)
    );

endmodule

// File: tb/tb_ha_result_packer.sv
// Self-checking bench for ha_result_packer (PACK_WIDTH=4): directed cases plus
// randomized traffic compared every cycle against a queue-based model.
module tb_ha_result_packer;

    localparam int unsigned PW = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned DW = 2 * PW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, sv, sd, cv, cd, fl, rdy;
    logic          s_sum_tready, s_carry_tready;
    logic          m_pack_tvalid;
    logic [DW-1:0] m_pack_tdata;
    logic [CW-1:0] m_pack_tcount;
`ifdef HA_PACK_CARRY_CNT_EN
    logic [CW-1:0] m_pack_tuser;
`endif

    ha_result_packer #(.PACK_WIDTH(PW)) dut (
        .clk            (clk),
        .reset          (rst),
        .s_sum_tvalid   (sv),
        .s_sum_tdata    (sd),
        .s_sum_tready   (s_sum_tready),
        .s_carry_tvalid (cv),
        .s_carry_tdata  (cd),
        .s_carry_tready (s_carry_tready),
        .flush          (fl),
        .m_pack_tvalid  (m_pack_tvalid),
        .m_pack_tdata   (m_pack_tdata),
        .m_pack_tcount  (m_pack_tcount),
`ifdef HA_PACK_CARRY_CNT_EN
        .m_pack_tuser   (m_pack_tuser),
`endif
        .m_pack_tready  (rdy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: pairs waiting in the accumulator ({carry,sum}), one output slot
    logic [1:0]    m_acc[$];
    bit            m_ov   = 1'b0;
    bit            m_pend = 1'b0;
    logic [DW-1:0] m_word = '0;
    int            m_cnt  = 0;
    int            m_ones = 0;

    // Beats actually handed downstream, for the directed checks
    logic [DW-1:0] beat_data[$];
    int            beat_cnt[$];
    int            beat_user[$];
    bit            fired;

    task automatic tick();
        bit exp_rdy;
        bit free;
        bit done;
        #1;
        exp_rdy = !rst && sv && cv && (m_acc.size() < PW) && !m_pend;
        chk("sum_tready",   64'(s_sum_tready),   64'(exp_rdy));
        chk("carry_tready", 64'(s_carry_tready), 64'(exp_rdy));
        chk("tvalid",       64'(m_pack_tvalid),  64'(m_ov));
        if (m_ov || m_cnt == 0) begin
            chk("tdata",  64'(m_pack_tdata),  64'(m_word));
            chk("tcount", 64'(m_pack_tcount), 64'(m_cnt));
`ifdef HA_PACK_CARRY_CNT_EN
            chk("tuser",  64'(m_pack_tuser),  64'(m_ones));
`endif
        end
        fired = sv && s_sum_tready;
        if (!rst && m_pack_tvalid && rdy) begin
            beat_data.push_back(m_pack_tdata);
            beat_cnt.push_back(int'(m_pack_tcount));
`ifdef HA_PACK_CARRY_CNT_EN
            beat_user.push_back(int'(m_pack_tuser));
`endif
        end
        if (rst) begin
            m_acc.delete();
            m_ov = 0; m_pend = 0; m_word = '0; m_cnt = 0; m_ones = 0;
        end else begin
            free = !m_ov || rdy;
            if (exp_rdy) m_acc.push_back({cd, sd});
            done = (m_acc.size() == PW) || ((fl || m_pend) && m_acc.size() > 0);
            if (free) begin
                m_ov = 0;
                if (done) begin
                    m_ov = 1;
                    m_word = '0;
                    m_ones = 0;
                    for (int k = 0; k < m_acc.size(); k++) begin
                        m_word[k]      = m_acc[k][0];
                        m_word[PW + k] = m_acc[k][1];
                        m_ones += int'(m_acc[k][1]);
                    end
                    m_cnt = m_acc.size();
                    m_acc.delete();
                    m_pend = 0;
                end
            end else if (done && m_acc.size() < PW) begin
                m_pend = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_pair(input logic s, input logic c);
        int n;
        sv = 1; cv = 1; sd = s; cd = c;
        tick();
        n = 0;
        while (!fired && n < 50) begin
            tick();
            n++;
        end
        if (!fired) chk("send_timeout", 64'(0), 64'(1));
        sv = 0; cv = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_flush();
        fl = 1;
        tick();
        fl = 0;
    endtask

    task automatic chk_beat(input int idx, input logic [DW-1:0] data, input int cnt);
        if (idx < beat_data.size()) begin
            chk("beat_data",  64'(beat_data[idx]), 64'(data));
            chk("beat_count", 64'(beat_cnt[idx]),  64'(cnt));
        end else begin
            chk("beat_missing", 64'(beat_data.size()), 64'(idx + 1));
        end
    endtask

    task automatic clear_beats();
        beat_data.delete();
        beat_cnt.delete();
        beat_user.delete();
    endtask

    initial begin
        rst = 1; sv = 0; sd = 0; cv = 0; cd = 0; fl = 0; rdy = 1;
        @(negedge clk);

        // Reset held with both valids high, then a full word 8'h83
        sv = 1; cv = 1; sd = 1; cd = 0;
        idle(2);
        rst = 0;
        tick();
        chk("first_handshake", 64'(fired), 64'(1));
        sd = 1; cd = 0; tick();
        sd = 0; cd = 0; tick();
        sd = 0; cd = 1; tick();
        sv = 0; cv = 0;
        idle(3);
        chk("full_beats", 64'(beat_data.size()), 64'(1));
        chk_beat(0, 8'h83, 4);
`ifdef HA_PACK_CARRY_CNT_EN
        if (beat_user.size() > 0) chk("full_tuser", 64'(beat_user[0]), 64'(1));
`endif

        // Back-pressure: two words buffered, ninth pair stalls
        clear_beats();
        rdy = 0;
        send_pair(1, 1); send_pair(0, 0); send_pair(1, 0); send_pair(0, 1);
        send_pair(0, 0); send_pair(0, 0); send_pair(1, 1); send_pair(1, 1);
        sv = 1; cv = 1; sd = 1; cd = 0;
        repeat (3) begin
            tick();
            chk("stall_9th", 64'(fired), 64'(0));
        end
        rdy = 1;
        send_pair(1, 0);
        idle(3);
        do_flush();
        idle(3);
        chk("bp_beats", 64'(beat_data.size()), 64'(3));
        chk_beat(0, 8'h95, 4);
        chk_beat(1, 8'hCC, 4);
        chk_beat(2, 8'h01, 1);

        // Join mismatch: lone sum valid never transfers
        clear_beats();
        sv = 1; cv = 0; sd = 1; cd = 1;
        repeat (5) begin
            tick();
            chk("lone_valid", 64'(fired), 64'(0));
        end
        cv = 1;
        tick();
        chk("join_fire", 64'(fired), 64'(1));
        sv = 0; cv = 0;
        idle(2);
        do_flush();
        idle(3);
        chk("join_beats", 64'(beat_data.size()), 64'(1));
        chk_beat(0, 8'h11, 1);

        // Flush of a partial word, then flush of an empty accumulator
        clear_beats();
        send_pair(1, 1); send_pair(0, 1);
        idle(1);
        do_flush();
        idle(3);
        do_flush();
        idle(3);
        chk("flush_beats", 64'(beat_data.size()), 64'(1));
        chk_beat(0, 8'h31, 2);

        // Reset mid-word discards the partial word
        clear_beats();
        send_pair(1, 1); send_pair(1, 1); send_pair(1, 1);
        rst = 1; tick(); rst = 0;
        repeat (4) send_pair(0, 1);
        idle(3);
        do_flush();
        idle(3);
        chk("rst_mid_beats", 64'(beat_data.size()), 64'(1));
        chk_beat(0, 8'hF0, 4);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            sv  = ($urandom_range(0, 3) != 0);
            cv  = ($urandom_range(0, 3) != 0);
            sd  = 1'($urandom);
            cd  = 1'($urandom);
            fl  = ($urandom_range(0, 14) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            tick();
        end
        rst = 0; sv = 0; cv = 0; fl = 0; rdy = 1;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
